conv2d_tile_engine: RTL and testbench
=====================================

Name: conv2d_tile_engine

Overview:
- Parametrised 2-D convolution tile engine: computes one OUT x OUT output tile from a (OUT+K-1) x (OUT+K-1) input tile and a K x K kernel.
- Time-multiplexes LANES external DSP multipliers, tolerating pipelined DSP latency.
- Sits between the tile buffer and the DSP slice bank in the NPU datapath.
- Additions over the fixed 3x3/4x4 engine: signed mode, accumulator clear on start, latency-tracked accumulation, output saturation, busy/done handshake.

Parameters:
- DW, 8, input/kernel element width; legal range 2..17.
- K, 3, kernel dimension.
- OUT, 4, output tile dimension; input tile dimension T = OUT+K-1.
- LANES, 5, number of DSP lanes; legal range 1..OUT*OUT.
- DSP_LAT, 1, DSP cycles from operand register to valid dsp_out; minimum 1.
- ACCW, 20, accumulator width.
- OW, 16, output element width; OW <= ACCW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a tile computation; sampled only while idle.
- signed_mode  in  1  1 = operands and products two's complement; sampled with start.
- input_tile  in  DW, unpacked [0:T-1][0:T-1]  input tile; must stay stable while busy.
- kernel  in  DW, unpacked [0:K-1][0:K-1]  kernel; must stay stable while busy.
- dsp_a  out  18, unpacked [0:LANES-1]  DSP A operands, registered.
- dsp_b  out  18, unpacked [0:LANES-1]  DSP B operands, registered.
- dsp_out  in  37, unpacked [0:LANES-1]  DSP products.
- dsp_ce  out  1  DSP clock enable.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- c  out  OW, unpacked [0:OUT-1][0:OUT-1]  saturated result tile, registered.

Behaviour:
- Reset: all outputs 0; accumulators 0; state IDLE.
- Reset is asynchronous, clears everything mid-operation, and discards in-flight results.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE:
  - start=1 accepts at edge T0: latch signed_mode, clear all accumulators, busy=1, dsp_ce=1, enter ISSUE.
  - c is held unchanged.
- Schedule:
  - Output pixel p = r*OUT+col (row-major). G = ceil(OUT*OUT/LANES) groups.
  - Issue index i = g*K*K + m*K + n, tap (m,n) row-major inside group g. N = G*K*K issue cycles.
  - Lane l of group g serves p = g*LANES+l: dsp_a = input_tile[r+m][col+n], dsp_b = kernel[m][n].
  - Lanes with p >= OUT*OUT drive 0/0 and their results are discarded.
- Operand extension: zero-extend to 18 bits when unsigned, sign-extend when signed.
- Issue i appears on dsp_a/dsp_b in cycle T0+1+i.
- A DSP_LAT-deep valid/pixel-tag shift register tracks each issue. dsp_out for issue i is consumed at the end of cycle T0+1+i+DSP_LAT.
- Accumulation: acc[p] += dsp_out[l][ACCW-1:0], treated as signed in signed mode. Wrap-around modulo 2^ACCW; no intermediate saturation.
- ISSUE ends after issue N-1; DRAIN waits until the tag pipeline is empty. After the last issue, dsp_a/dsp_b are driven to 0.
- Completion:
  - Cycle T0+N+DSP_LAT+1: done=1 for exactly one cycle and c is loaded.
  - Same edge: busy=0, dsp_ce=0, return to IDLE.
  - Total latency from start edge to done cycle = N+DSP_LAT+1.
- Saturation into OW bits:
  - unsigned: acc > 2^OW-1 -> 2^OW-1.
  - signed: clamp to [-2^(OW-1), 2^(OW-1)-1].
- c and accumulators stay stable until the next accepted start.
- start while busy is ignored; no queueing. start coincident with done is ignored, since busy is still 1 in that cycle.
- start held high continuously: a new run is accepted on the first edge after returning to IDLE.
- signed_mode changes while busy have no effect.

Test Plan:
- Defaults, unsigned, input all 1, kernel all 1 -> every c = 9. N = 36, so done pulses exactly 38 cycles after the start edge; busy high for 38 cycles.
- Defaults, signed_mode=1, input all 8'hFF (-1), kernel all 2 -> every c = 16'hFFEE (-18).
- Unsigned, input all 255, kernel all 255 -> acc = 585225 -> every c = 16'hFFFF. Signed, input all -128, kernel all -128 -> acc = 147456 -> every c = 16'h7FFF.
- Input ramp input_tile[i][j] = i*6+j, kernel identity-centre (kernel[1][1]=1, rest 0) -> c[r][col] = (r+1)*6+(col+1). Then start pulses while busy -> ignored. Second run with kernel all 0 -> all c = 0, proving accumulators clear on start.
- Assert rst_n low mid-ISSUE (cycle 10 after start) -> c, busy, dsp_ce, dsp_a/dsp_b all 0 immediately. Fresh start then yields the correct result with no residue.
- LANES=16, DSP_LAT=3, unsigned all 1s -> N = 9, done exactly 13 cycles after start, every c = 9.

Source files
------------

// File: rtl/conv2d_tile_engine.sv
// 2-D convolution tile engine: one OUT x OUT output tile from a (OUT+K-1)^2 input tile
// and a K x K kernel, time-multiplexed over LANES pipelined external DSP multipliers.
module conv2d_tile_engine #(
    parameter int DW      = 8,
    parameter int K       = 3,
    parameter int OUT     = 4,
    parameter int LANES   = 5,
    parameter int DSP_LAT = 1,
    parameter int ACCW    = 20,
    parameter int OW      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                signed_mode,
    input  logic [DW-1:0]       input_tile [0:OUT+K-2][0:OUT+K-2],
    input  logic [DW-1:0]       kernel [0:K-1][0:K-1],
    output logic [17:0]         dsp_a [0:LANES-1],
    output logic [17:0]         dsp_b [0:LANES-1],
    input  logic [36:0]         dsp_out [0:LANES-1],
    output logic                dsp_ce,
    output logic                busy,
    output logic                done,
    output logic [OW-1:0]       c [0:OUT-1][0:OUT-1]
);

    localparam int NPIX = OUT * OUT;
    localparam int G    = (NPIX + LANES - 1) / LANES;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int KW   = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic signed [ACCW:0] SMAX = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACCW:0] SMIN = {{(ACCW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};
    localparam logic [ACCW:0]        UMAX = {{(ACCW + 1 - OW){1'b0}}, {OW{1'b1}}};

    function automatic logic [17:0] ext(input logic [DW-1:0] x, input logic sgn);
        if (sgn) begin
            ext = {{(18 - DW){x[DW-1]}}, x};
        end else begin
            ext = {{(18 - DW){1'b0}}, x};
        end
    endfunction

    function automatic logic [OW-1:0] sat(input logic [ACCW-1:0] a, input logic sgn);
        logic signed [ACCW:0] sv;
        logic [ACCW:0]        uv;
        sv = signed'({a[ACCW-1], a});
        uv = {1'b0, a};
        if (sgn) begin
            if (sv > SMAX)      sat = SMAX[OW-1:0];
            else if (sv < SMIN) sat = SMIN[OW-1:0];
            else                sat = a[OW-1:0];
        end else begin
            if (uv > UMAX) sat = {OW{1'b1}};
            else           sat = a[OW-1:0];
        end
    endfunction

    logic [1:0]      state_r;
    logic            sgn_r;
    logic [GW-1:0]   g_r;
    logic [KW-1:0]   m_r;
    logic [KW-1:0]   n_r;
    logic [17:0]     a_r [0:LANES-1];
    logic [17:0]     b_r [0:LANES-1];
    logic            busy_r;
    logic            ce_r;
    logic            done_r;
    logic [OW-1:0]   c_r [0:OUT-1][0:OUT-1];
    logic [ACCW-1:0] acc_r [0:NPIX-1];

    // Tag pipeline: stage 0 travels with the operand register, stage DSP_LAT meets dsp_out.
    logic            tag_v_r    [0:DSP_LAT];
    logic [GW-1:0]   tag_g_r    [0:DSP_LAT];
    logic            tag_last_r [0:DSP_LAT];

    logic [17:0]     op_a_s [0:LANES-1];
    logic [17:0]     op_b_s [0:LANES-1];
    logic [ACCW-1:0] acc_next_s [0:NPIX-1];
    logic            accept_s;
    logic            last_issue_s;
    logic            finish_s;

    assign accept_s     = (state_r == ST_IDLE) && start;
    assign last_issue_s = (g_r == GW'(G - 1)) && (m_r == KW'(K - 1)) && (n_r == KW'(K - 1));
    assign finish_s     = tag_v_r[DSP_LAT] && tag_last_r[DSP_LAT];

    assign dsp_a  = a_r;
    assign dsp_b  = b_r;
    assign dsp_ce = ce_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign c      = c_r;

    // Operand selection for the current group/tap; padding lanes drive zero.
    always_comb begin
        int pix;
        pix = 0;
        for (int l = 0; l < LANES; l++) begin
            op_a_s[l] = 18'd0;
            op_b_s[l] = 18'd0;
            pix = int'(g_r) * LANES + l;
            if (pix < NPIX) begin
                op_a_s[l] = ext(input_tile[pix / OUT + int'(m_r)][pix % OUT + int'(n_r)], sgn_r);
                op_b_s[l] = ext(kernel[m_r][n_r], sgn_r);
            end else begin
                op_a_s[l] = 18'd0;
                op_b_s[l] = 18'd0;
            end
        end
    end

    // Next accumulator values: a pixel adds its lane's product when its group's tag retires.
    always_comb begin
        for (int p = 0; p < NPIX; p++) begin
            acc_next_s[p] = acc_r[p];
            if (tag_v_r[DSP_LAT] && (tag_g_r[DSP_LAT] == GW'(p / LANES))) begin
                acc_next_s[p] = acc_r[p] + dsp_out[p % LANES][ACCW-1:0];
            end else begin
                acc_next_s[p] = acc_r[p];
            end
        end
    end

    // Control FSM, issue counters and registered DSP operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sgn_r   <= 1'b0;
            g_r     <= '0;
            m_r     <= '0;
            n_r     <= '0;
            busy_r  <= 1'b0;
            ce_r    <= 1'b0;
            done_r  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                a_r[l] <= 18'd0;
                b_r[l] <= 18'd0;
            end
        end else begin
            done_r <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                a_r[l] <= 18'd0;
                b_r[l] <= 18'd0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sgn_r   <= signed_mode;
                        g_r     <= '0;
                        m_r     <= '0;
                        n_r     <= '0;
                        busy_r  <= 1'b1;
                        ce_r    <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    a_r <= op_a_s;
                    b_r <= op_b_s;
                    if (last_issue_s) begin
                        g_r     <= '0;
                        m_r     <= '0;
                        n_r     <= '0;
                        state_r <= ST_DRAIN;
                    end else if (n_r == KW'(K - 1)) begin
                        n_r <= '0;
                        if (m_r == KW'(K - 1)) begin
                            m_r <= '0;
                            g_r <= g_r + 1'b1;
                        end else begin
                            m_r <= m_r + 1'b1;
                        end
                    end else begin
                        n_r <= n_r + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (finish_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        ce_r    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid/group/last tag shift register alongside the DSP pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d <= DSP_LAT; d++) begin
                tag_v_r[d]    <= 1'b0;
                tag_g_r[d]    <= '0;
                tag_last_r[d] <= 1'b0;
            end
        end else begin
            tag_v_r[0]    <= (state_r == ST_ISSUE);
            tag_g_r[0]    <= g_r;
            tag_last_r[0] <= (state_r == ST_ISSUE) && last_issue_s;
            for (int d = 1; d <= DSP_LAT; d++) begin
                tag_v_r[d]    <= tag_v_r[d-1];
                tag_g_r[d]    <= tag_g_r[d-1];
                tag_last_r[d] <= tag_last_r[d-1];
            end
        end
    end

    // Accumulators clear on accept; the result tile is loaded with the final sum on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NPIX; p++) begin
                acc_r[p] <= '0;
                c_r[p / OUT][p % OUT] <= '0;
            end
        end else begin
            for (int p = 0; p < NPIX; p++) begin
                if (accept_s) begin
                    acc_r[p] <= '0;
                end else begin
                    acc_r[p] <= acc_next_s[p];
                end
                if ((state_r == ST_DRAIN) && finish_s) begin
                    c_r[p / OUT][p % OUT] <= sat(acc_next_s[p], sgn_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2d_tile_engine.sv
// Randomised and directed bench for conv2d_tile_engine against a plain-arithmetic convolution model.
module tb_conv2d_tile_engine;
    localparam int DW = 8;
    localparam int K = 3;
    localparam int OUT = 4;
    localparam int T = OUT + K - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start1, start2, sgn;
    logic [DW-1:0] in_t [0:T-1][0:T-1];
    logic [DW-1:0] kern [0:K-1][0:K-1];

    logic [17:0] a1 [0:4];
    logic [17:0] b1 [0:4];
    logic [36:0] o1 [0:4];
    logic [36:0] pipe1 [0:4];
    logic        ce1, busy1, done1;
    logic [15:0] c1 [0:OUT-1][0:OUT-1];

    logic [17:0] a2 [0:15];
    logic [17:0] b2 [0:15];
    logic [36:0] o2 [0:15];
    logic [36:0] pipe2 [0:15][0:2];
    logic        ce2, busy2, done2;
    logic [15:0] c2 [0:OUT-1][0:OUT-1];

    logic [15:0] exp_c [0:OUT-1][0:OUT-1];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    conv2d_tile_engine dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sgn),
        .input_tile(in_t), .kernel(kern), .dsp_a(a1), .dsp_b(b1), .dsp_out(o1),
        .dsp_ce(ce1), .busy(busy1), .done(done1), .c(c1)
    );

    conv2d_tile_engine #(.LANES(16), .DSP_LAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sgn),
        .input_tile(in_t), .kernel(kern), .dsp_a(a2), .dsp_b(b2), .dsp_out(o2),
        .dsp_ce(ce2), .busy(busy2), .done(done2), .c(c2)
    );

    // External DSP slices: 18x18 signed multiply with DSP_LAT register stages.
    function automatic logic [36:0] dsp_mul(input logic [17:0] a, input logic [17:0] b);
        dsp_mul = {{19{a[17]}}, a} * {{19{b[17]}}, b};
    endfunction

    always_ff @(posedge clk) begin
        if (ce1) for (int l = 0; l < 5; l++) pipe1[l] <= dsp_mul(a1[l], b1[l]);
    end
    assign o1 = pipe1;

    always_ff @(posedge clk) begin
        if (ce2) begin
            for (int l = 0; l < 16; l++) begin
                pipe2[l][0] <= dsp_mul(a2[l], b2[l]);
                pipe2[l][1] <= pipe2[l][0];
                pipe2[l][2] <= pipe2[l][1];
            end
        end
    end
    always_comb for (int l = 0; l < 16; l++) o2[l] = pipe2[l][2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision convolution, wrapped to 20 bits, then clamped to 16 bits.
    task automatic model(input logic s);
        longint sum, va, vb, v;
        logic [63:0] wide;
        logic [19:0] w;
        for (int r = 0; r < OUT; r++) begin
            for (int col = 0; col < OUT; col++) begin
                sum = 0;
                for (int m = 0; m < K; m++) begin
                    for (int n = 0; n < K; n++) begin
                        va = s ? {{56{in_t[r+m][col+n][7]}}, in_t[r+m][col+n]} : {56'd0, in_t[r+m][col+n]};
                        vb = s ? {{56{kern[m][n][7]}}, kern[m][n]} : {56'd0, kern[m][n]};
                        sum += va * vb;
                    end
                end
                wide = sum;
                w = wide[19:0];
                v = s ? {{44{w[19]}}, w} : {44'd0, w};
                if (s && v > 32767) v = 32767;
                else if (s && v < -32768) v = -32768;
                else if (!s && v > 65535) v = 65535;
                wide = v;
                exp_c[r][col] = wide[15:0];
            end
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 1) ? busy1 : busy2;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 1) ? done1 : done2;
    endfunction
    function automatic logic [15:0] c_of(input int w, input int r, input int col);
        return (w == 1) ? c1[r][col] : c2[r][col];
    endfunction

    task automatic fill(input int mode, input logic [7:0] iv, input logic [7:0] kv);
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                in_t[i][j] = (mode == 0) ? iv : (mode == 1) ? 8'(i * 6 + j) : 8'($urandom_range(0, 255));
        for (int m = 0; m < K; m++)
            for (int n = 0; n < K; n++)
                kern[m][n] = (mode == 0) ? kv : (mode == 1) ? ((m == 1 && n == 1) ? 8'd1 : 8'd0)
                                                             : 8'($urandom_range(0, 255));
    endtask

    task automatic run(input int which, input logic s, input int lat, input bit poke);
        int cyc, busy_cnt;
        bit got;
        model(s);
        @(negedge clk);
        sgn = s;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        busy_cnt = busy_of(which) ? 1 : 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            if (poke && (cyc == 5 || cyc == lat - 1)) start1 = 1'b1; else start1 = 1'b0;
            if (poke && cyc == 3) sgn = ~s;
            @(posedge clk); #1;
            cyc++;
            if (done_of(which)) got = 1'b1;
            else if (busy_of(which)) busy_cnt++;
        end
        start1 = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("latency", 64'(cyc), 64'(lat));
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
        check("busy_at_done", 64'(busy_of(which)), 64'd0);
        for (int r = 0; r < OUT; r++)
            for (int col = 0; col < OUT; col++)
                check($sformatf("c[%0d][%0d]", r, col), 64'(c_of(which, r, col)), 64'(exp_c[r][col]));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done_of(which)), 64'd0);
        check("idle_after", 64'(busy_of(which)), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        sgn = 1'b0;
        fill(0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_ce", 64'(ce1), 64'd0);
        check("rst_c", 64'(c1[1][1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(0, 8'd1, 8'd1);
        run(1, 1'b0, 38, 1'b0);
        check("ones_c", 64'(c1[2][3]), 64'd9);

        fill(2, 8'd0, 8'd0);
        @(negedge clk);
        sgn = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy1), 64'd0);
        check("midrst_ce", 64'(ce1), 64'd0);
        for (int r = 0; r < OUT; r++)
            for (int col = 0; col < OUT; col++)
                check("midrst_c", 64'(c1[r][col]), 64'd0);
        for (int l = 0; l < 5; l++) begin
            check("midrst_a", 64'(a1[l]), 64'd0);
            check("midrst_b", 64'(b1[l]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 1'b0, 38, 1'b0);

        fill(0, 8'hFF, 8'd2);
        run(1, 1'b1, 38, 1'b0);
        check("neg_c", 64'(c1[0][0]), 64'hFFEE);

        fill(0, 8'd255, 8'd255);
        run(1, 1'b0, 38, 1'b0);
        check("usat_c", 64'(c1[3][0]), 64'hFFFF);
        fill(0, 8'h80, 8'h80);
        run(1, 1'b1, 38, 1'b0);
        check("ssat_c", 64'(c1[1][2]), 64'h7FFF);

        fill(1, 8'd0, 8'd0);
        run(1, 1'b0, 38, 1'b1);
        check("ramp_c", 64'(c1[3][3]), 64'd28);
        fill(0, 8'd7, 8'd0);
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                in_t[i][j] = 8'(i * 6 + j);
        run(1, 1'b0, 38, 1'b0);
        check("kzero_c", 64'(c1[2][2]), 64'd0);

        for (int k = 0; k < 4; k++) begin
            fill(2, 8'd0, 8'd0);
            run(1, 1'($urandom_range(0, 1)), 38, 1'b0);
        end

        fill(0, 8'd1, 8'd1);
        run(2, 1'b0, 13, 1'b0);
        check("wide_c", 64'(c2[3][1]), 64'd9);
        fill(2, 8'd0, 8'd0);
        run(2, 1'b1, 13, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
